// File: rtl/systemverilog_bus_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   - BUS_AW_DEF / BUS_DW_DEF : default address / data widths
//   - arb_state_e             : arbiter FSM state (IDLE, BUSY)
//   - bus_req_t               : one requester's {adr, dat} at the default widths
//   - ptr_width()             : width of a requester index (at least 1 bit)
package systemverilog_bus_pkg;

  localparam int unsigned BUS_AW_DEF = 32;
  localparam int unsigned BUS_DW_DEF = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [BUS_AW_DEF-1:0] adr;
    logic [BUS_DW_DEF-1:0] dat;
  } bus_req_t;

  // A single requester still needs a 1-bit pointer so that ports stay legal.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systemverilog_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req   [N]  : request vector
//   ptr   [PW] : index of the last winner; the search starts at ptr+1 (mod N)
//   pick  [N]  : one-hot winner (0 when no request)
//   valid      : at least one request present
// The search is a rotate of {req, req} by the start index, a lowest-set-bit
// isolate, and a rotate back that folds the two halves together.
module systemverilog_rr_picker
  import systemverilog_bus_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [PW-1:0]  start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_oh;
  logic [2*N-1:0] back;

  // Wrap explicitly so non-power-of-two N never starts on an invalid index.
  assign start = (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);

  assign dbl    = {req, req};
  assign rot    = N'(dbl >> start);
  // Two's-complement trick: keeps only the lowest set bit.
  assign rot_oh = rot & (~rot + N'(1));
  // Rotating back may land in either half; OR-ing them completes the wrap.
  assign back   = {{N{1'b0}}, rot_oh} << start;
  assign pick   = back[N-1:0] | back[2*N-1:N];
  assign valid  = |req;

endmodule

// File: rtl/systemverilog_bus_arbiter.sv
// Round-robin arbiter sharing one bus port between N requesters.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   bsi_vld [N]      : per-requester valid (held until rdy)
//   bsi_adr [N][AW]  : per-requester address
//   bsi_dat [N][DW]  : per-requester data
//   bsi_rdy [N]      : per-requester acknowledge (only the granted one)
//   bsi_lck [N]      : lock request, present only with SYSTEMVERILOG_BUS_ARB_LOCK_EN
//   bso_vld/adr/dat  : shared bus request toward the serializer
//   bso_rdy          : shared bus ready
//   gnt [N]          : one-hot current grant, 0 when idle
// Optional build macro: SYSTEMVERILOG_BUS_ARB_LOCK_EN. When defined, a locked
// completion keeps the grant so a requester can burst one transfer per cycle.
module systemverilog_bus_arbiter
  import systemverilog_bus_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = BUS_AW_DEF,
  parameter int unsigned DW = BUS_DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         bsi_vld,
  input  logic [N-1:0][AW-1:0] bsi_adr,
  input  logic [N-1:0][DW-1:0] bsi_dat,
  output logic [N-1:0]         bsi_rdy,
`ifdef SYSTEMVERILOG_BUS_ARB_LOCK_EN
  input  logic [N-1:0]         bsi_lck,
`endif
  output logic                 bso_vld,
  output logic [AW-1:0]        bso_adr,
  output logic [DW-1:0]        bso_dat,
  input  logic                 bso_rdy,
  output logic [N-1:0]         gnt
);

  localparam int unsigned PW = ptr_width(N);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q,   gnt_d;
  logic [PW-1:0] ptr_q,   ptr_d;

  logic [N-1:0]  pick;
  logic          pick_valid;
  logic [PW-1:0] gnt_idx;
  logic          xfer_done;
  logic          lock_hold;

  systemverilog_rr_picker #(
    .N  (N),
    .PW (PW)
  ) u_picker (
    .req   (bsi_vld),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // AND-OR mux on the registered one-hot grant; a zero grant yields zero
  // address/data, so the shared bus is quiet while idle.
  always_comb begin
    bso_adr = '0;
    bso_dat = '0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        bso_adr = bso_adr | bsi_adr[i];
        bso_dat = bso_dat | bsi_dat[i];
        gnt_idx = gnt_idx | PW'(i);
      end
    end
  end

  assign bso_vld   = |(gnt_q & bsi_vld);
  assign bsi_rdy   = gnt_q & {N{bso_rdy}};
  assign gnt       = gnt_q;
  assign xfer_done = bso_vld & bso_rdy;

`ifdef SYSTEMVERILOG_BUS_ARB_LOCK_EN
  assign lock_hold = |(gnt_q & bsi_lck);
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer_done) begin
          // Completion moves the pointer so the winner gets lowest priority.
          if (!lock_hold) begin
            gnt_d   = '0;
            state_d = ST_IDLE;
            ptr_d   = gnt_idx;
          end
        end else if (!bso_vld) begin
          // Requester withdrew: release without touching fairness state.
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= PW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
